wb_stage_rf: RTL
================

Name: wb_stage_rf

Overview:
- Write-back end of the MEM/WB pipeline register, with the integer register file it writes.
- Consumes WB_ALU_RES, WB_DM_Q, WB_RF_D_SEL, destination and write-enable.
- Selects write-back data and commits it to a 32-entry register file.
- Serves the two ID-stage read ports with same-cycle write-through bypass, and keeps a retired-instruction counter and a sticky illegal-select flag.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, number of architectural registers; entry 0 is hardwired to zero.
- AW, 5, register address width, equal to clog2(NREG).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_alu_res  in  XLEN  ALU result from MEM/WB.
- wb_dm_q  in  XLEN  data-memory read word from MEM/WB.
- wb_pc4  in  XLEN  PC+4 of the instruction in WB, used for link writes.
- wb_rf_d_sel  in  2  data select: 0=ALU, 1=DM, 2=PC4, 3=illegal.
- wb_rd  in  AW  destination register.
- wb_we  in  1  register write request.
- wb_valid  in  1  WB slot holds a real instruction, not a bubble.
- wb_ld_size  in  2  load size: 0=byte, 1=half, 2=word. Used only with WB_LOAD_EXT_EN.
- wb_ld_uns  in  1  zero-extend instead of sign-extend. Used only with WB_LOAD_EXT_EN.
- wb_addr_lo  in  2  low address bits of the load. Used only with WB_LOAD_EXT_EN.
- rs1_addr, rs2_addr  in  AW  ID-stage read addresses.
- rs1_data, rs2_data  out  XLEN  read data, combinational.
- wb_data  out  XLEN  selected write-back value, combinational; also the forwarding source for EX.
- retire_cnt  out  32  count of retired instructions.
- sel_err  out  1  sticky flag: an illegal select was seen.

Behaviour:
- Reset (asynchronous, rst_n=0): all NREG entries = 0, retire_cnt = 0, sel_err = 0. Reads during reset return 0.
- wb_data mux:
  - sel 0 → wb_alu_res.
  - sel 1 → load path: raw wb_dm_q, or the extended value with the feature enabled.
  - sel 2 → wb_pc4.
  - sel 3 → 0.
- Commit condition: wb_valid & wb_we & (wb_rd != 0) & (wb_rf_d_sel != 3). On the rising edge, rf[wb_rd] <= wb_data. Latency is 1 cycle to the array.
- Reads: rsN_data = 0 if rsN_addr == 0.
  - Otherwise, wb_data if the commit condition holds and wb_rd == rsN_addr (write-through bypass, so ID sees the value in the same cycle).
  - Otherwise rf[rsN_addr].
- Both ports may read the same address, including the one being written; both get the bypassed value.
- retire_cnt increments by 1 every edge with wb_valid = 1, whether or not a write happens. It wraps 0xFFFFFFFF → 0.
- sel_err is set on any edge with wb_valid & wb_we & sel == 3. No write occurs; the counter still increments. It is cleared only by reset.
- Bubbles (wb_valid = 0) change nothing, whatever the other inputs are.
- Writes to x0 are dropped and x0 always reads 0.
- Reset asserted mid-operation: the array and counter clear immediately. The first edge after deassertion behaves normally.

Optional Feature:
- Macro: WB_LOAD_EXT_EN.
- With the macro defined, the sel=1 path extracts a byte or half from wb_dm_q by wb_addr_lo, little-endian.
  - byte: lane wb_addr_lo.
  - half: lane wb_addr_lo[1].
  - Result is sign- or zero-extended per wb_ld_uns.
  - Size 3 is treated as word.
- Without the macro, the sel=1 path uses wb_dm_q unmodified. The three ports stay declared but are ignored, so they may be tied to 0.

Decomposition:
- Package wb_pkg holds:
  - RF_SEL_ALU/DM/PC4/ILL localparams.
  - LD_BYTE/HALF/WORD constants.
  - XLEN/AW defaults.
- Sub-module wb_load_align: combinational byte/half extract and extend. Instantiated only under WB_LOAD_EXT_EN.

Test Plan:
- Reset then read all 32 addresses → all 0. retire_cnt = 0, sel_err = 0.
- Write x5 with sel=0, alu=0x12345678, valid=1, we=1, and rs1_addr=5 in the same cycle → rs1_data = 0x12345678 combinationally. After the edge, rf[5] = 0x12345678 and retire_cnt = 1.
- Write x0 with 0xFFFFFFFF → rs1/rs2 at address 0 read 0. retire_cnt increments.
- sel=3, rd=7, we=1, valid=1 → x7 unchanged, sel_err = 1 and held; 10 bubbles afterward leave retire_cnt unchanged.
- With WB_LOAD_EXT_EN: dm_q=0x80FF7F01.
  - byte, lo=2, signed → 0xFFFFFFFF.
  - byte, lo=3, unsigned → 0x00000080.
  - half, lo=2, signed → 0xFFFF80FF.
- Preload retire_cnt near wrap via 2^32−1 forced retires, or force the counter → next valid edge gives 0. Then assert rst_n low mid-cycle → array and count clear without waiting for a clock edge.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the write-back stage and its register file.
// Load-select codes, load sizes and default datapath widths.
package wb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;

    localparam logic [1:0] RF_SEL_ALU = 2'd0;
    localparam logic [1:0] RF_SEL_DM  = 2'd1;
    localparam logic [1:0] RF_SEL_PC4 = 2'd2;
    localparam logic [1:0] RF_SEL_ILL = 2'd3;

    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_WORD = 2'd2;

endpackage

// File: rtl/wb_load_align.sv
// Little-endian byte/half extraction with sign or zero extension.
// Only instantiated when WB_LOAD_EXT_EN is defined.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] dm_q_i,
    input  logic [1:0]      size_i,
    input  logic            uns_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    assign byte_w = dm_q_i[{addr_lo_i, 3'b000} +: 8];
    assign half_w = dm_q_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Size 3 falls through to the full word.
    always_comb begin
        data_o = dm_q_i;
        unique case (size_i)
            LD_BYTE: data_o = {{(XLEN-8){byte_w[7] & ~uns_i}}, byte_w};
            LD_HALF: data_o = {{(XLEN-16){half_w[15] & ~uns_i}}, half_w};
            default: data_o = dm_q_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_rf.sv
// Write-back select, 32-entry register file with write-through reads.
// Optional load extension on the DM path under WB_LOAD_EXT_EN.
module wb_stage_rf
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] wb_alu_res,
    input  logic [XLEN-1:0] wb_dm_q,
    input  logic [XLEN-1:0] wb_pc4,
    input  logic [1:0]      wb_rf_d_sel,
    input  logic [AW-1:0]   wb_rd,
    input  logic            wb_we,
    input  logic            wb_valid,
    input  logic [1:0]      wb_ld_size,
    input  logic            wb_ld_uns,
    input  logic [1:0]      wb_addr_lo,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     retire_cnt,
    output logic            sel_err
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [31:0]     retire_cnt_q, retire_cnt_d;
    logic            sel_err_q, sel_err_d;
    logic [XLEN-1:0] ld_data;
    logic            commit;

`ifdef WB_LOAD_EXT_EN
    wb_load_align #(.XLEN(XLEN)) u_align (
        .dm_q_i    (wb_dm_q),
        .size_i    (wb_ld_size),
        .uns_i     (wb_ld_uns),
        .addr_lo_i (wb_addr_lo),
        .data_o    (ld_data)
    );
`else
    logic unused_ld;
    assign unused_ld = ^{wb_ld_size, wb_ld_uns, wb_addr_lo};
    assign ld_data   = wb_dm_q;
`endif

    always_comb begin
        wb_data = '0;
        unique case (wb_rf_d_sel)
            RF_SEL_ALU: wb_data = wb_alu_res;
            RF_SEL_DM:  wb_data = ld_data;
            RF_SEL_PC4: wb_data = wb_pc4;
            default:    wb_data = '0;
        endcase
    end

    assign commit = wb_valid & wb_we & (wb_rd != '0)
                  & (wb_rf_d_sel != RF_SEL_ILL);

    // Reads are forced to zero while reset is held, bypass included.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rst_n && rs1_addr != '0)
            rs1_data = (commit && wb_rd == rs1_addr) ? wb_data
                                                     : rf_q[rs1_addr];
        if (rst_n && rs2_addr != '0)
            rs2_data = (commit && wb_rd == rs2_addr) ? wb_data
                                                     : rf_q[rs2_addr];
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        sel_err_d    = sel_err_q;
        if (wb_valid)
            retire_cnt_d = retire_cnt_q + 32'd1;
        if (wb_valid && wb_we && wb_rf_d_sel == RF_SEL_ILL)
            sel_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
            retire_cnt_q <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            if (commit)
                rf_q[wb_rd] <= wb_data;
            retire_cnt_q <= retire_cnt_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign sel_err    = sel_err_q;

endmodule
